// File: rtl/mod_accum_seq.sv
// Dot-product sequencer: streams terms into an external accumulator pipe, then reduces its result mod MODULUS.
// Result appears 5 cycles after capture. in_ready is high only while feeding. The result is held until res_ready.
module mod_accum_seq #(
  parameter int MODULUS    = 177147,
  parameter int LEN_W      = 8,
  parameter int PIPE_LAT   = 4,
  parameter int TRUNC_TAIL = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [20:0]      in_data,
  output logic             in_ready,
  output logic [20:0]      digit_in,
  output logic             clear_1,
  output logic             clear_2,
  output logic             clear_3,
  output logic             trunc_ena,
  input  logic [21:0]      accum_,
  output logic             busy,
  output logic             res_valid,
  output logic [17:0]      res_data,
  input  logic             res_ready
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [2:0] {S_IDLE, S_FEED, S_DRAIN, S_REDUCE, S_OUT} state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_thr;
  logic [DW-1:0]    r_dcnt;
  logic [2:0]       r_k;
  logic [21:0]      r_acc;
  logic [20:0]      r_digit;
  logic             r_clear_1;
  logic             r_clear_2;
  logic             r_clear_3;
  logic             r_trunc;
  logic             r_res_valid;
  logic [17:0]      r_res_data;

  logic             w_xfer;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [LEN_W-1:0] w_thr;
  logic [21:0]      w_sub;
  logic [21:0]      w_acc_nxt;

  assign w_xfer    = (r_state == S_FEED) && in_valid;
  assign w_cnt_inc = r_cnt + 1'b1;
  // Index of the first term that must run with truncation disabled.
  assign w_thr     = (int'(len) > TRUNC_TAIL) ? LEN_W'(int'(len) - TRUNC_TAIL) : '0;

  // Binary long-division steps: subtract 16M, 8M, 4M, 2M, M in turn; r < 32M on entry.
  assign w_sub     = 22'((32'd16 >> r_k) * MODULUS);
  assign w_acc_nxt = (r_acc >= w_sub) ? (r_acc - w_sub) : r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_cnt       <= '0;
      r_thr       <= '0;
      r_dcnt      <= '0;
      r_k         <= '0;
      r_acc       <= '0;
      r_digit     <= '0;
      r_clear_1   <= 1'b1;
      r_clear_2   <= 1'b1;
      r_clear_3   <= 1'b1;
      r_trunc     <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_clear_2 <= r_clear_1;
      r_clear_3 <= r_clear_2;
      r_digit   <= '0;
      case (r_state)
        S_IDLE: begin
          if (start && (len != '0)) begin
            r_len     <= len;
            r_thr     <= w_thr;
            r_cnt     <= '0;
            r_clear_1 <= 1'b0;
            r_state   <= S_FEED;
          end
        end
        S_FEED: begin
          if (w_xfer) begin
            r_digit <= in_data;
            r_cnt   <= w_cnt_inc;
            if (r_cnt == r_thr) begin
              r_trunc <= 1'b0;
            end
            if (w_cnt_inc == r_len) begin
              r_dcnt  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (r_dcnt == DW'(PIPE_LAT - 1)) begin
            r_acc     <= accum_;
            r_k       <= '0;
            r_trunc   <= 1'b1;
            r_clear_1 <= 1'b1;
            r_state   <= S_REDUCE;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_REDUCE: begin
          r_acc <= w_acc_nxt;
          r_k   <= r_k + 1'b1;
          if (r_k == 3'd4) begin
            r_res_data  <= w_acc_nxt[17:0];
            r_res_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_FEED);
  assign busy      = (r_state != S_IDLE);
  assign digit_in  = r_digit;
  assign clear_1   = r_clear_1;
  assign clear_2   = r_clear_2;
  assign clear_3   = r_clear_3;
  assign trunc_ena = r_trunc;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;

endmodule

// File: tb/tb_mod_accum_seq.sv
// Bench for mod_accum_seq: an external adder pipe feeds accum_, and results are checked against sum mod 2^22 mod MODULUS.
module tb_mod_accum_seq;

  localparam int MODULUS    = 177147;
  localparam int PIPE_LAT   = 4;
  localparam int TRUNC_TAIL = 5;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [20:0] in_data;
  logic        in_ready;
  logic [20:0] digit_in;
  logic        clear_1, clear_2, clear_3;
  logic        trunc_ena;
  logic [21:0] accum_;
  logic        busy;
  logic        res_valid;
  logic [17:0] res_data;
  logic        res_ready;

  int n_chk = 0;
  int n_err = 0;

  logic        ovr_en;
  logic [21:0] ovr_val;
  logic [21:0] pipe_q [0:PIPE_LAT-2];
  logic [20:0] terms [$];
  logic        e1, e2, e3;

  mod_accum_seq #(
    .MODULUS(MODULUS), .LEN_W(8), .PIPE_LAT(PIPE_LAT), .TRUNC_TAIL(TRUNC_TAIL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .digit_in(digit_in), .clear_1(clear_1), .clear_2(clear_2), .clear_3(clear_3),
    .trunc_ena(trunc_ena), .accum_(accum_), .busy(busy),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External accumulator: adder plus delay stages, final PIPE_LAT edges after the last term.
  always @(posedge clk) begin
    pipe_q[0] <= clear_1 ? 22'd0 : pipe_q[0] + 22'(digit_in);
    for (int i = 1; i < PIPE_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign accum_ = ovr_en ? ovr_val : pipe_q[PIPE_LAT-2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_step(input logic c1);
    e3 = e2; e2 = e1; e1 = c1;
    check("clear_1", clear_1, e1);
    check("clear_2", clear_2, e2);
    check("clear_3", clear_3, e3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_digit"}, digit_in, 0);
    check({tag, "_clr1"}, clear_1, 1);
    check({tag, "_clr2"}, clear_2, 1);
    check({tag, "_clr3"}, clear_3, 1);
    check({tag, "_trunc"}, trunc_ena, 1);
    check({tag, "_rvld"}, res_valid, 0);
    check({tag, "_rdata"}, res_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_inrdy"}, in_ready, 0);
  endtask

  task automatic fill(input int n, input int big);
    terms.delete();
    for (int i = 0; i < n; i++)
      terms.push_back(big != 0 ? 21'(21'h1FFFFF - $urandom_range(0, 5000)) : 21'($urandom_range(0, 200000)));
  endtask

  // gap: 0 = back-to-back, 1 = bubble every other cycle, 2 = random bubbles.
  task automatic run_txn(input int L, input int gap, input int hold, input logic use_ovr, input logic [21:0] ovr);
    int          thr, n, guard;
    logic        vld;
    logic [31:0] sum, expv, expd;
    thr = (L > TRUNC_TAIL) ? L - TRUNC_TAIL : 0;
    n = 0; guard = 0; sum = 0;
    ovr_en = use_ovr; ovr_val = ovr;
    e1 = 1'b1; e2 = 1'b1; e3 = 1'b1;
    @(negedge clk); start = 1'b1; len = 8'(L);
    @(negedge clk); start = 1'b0; len = 8'($urandom);
    check("busy_feed", busy, 1);
    clr_step(1'b0);
    while (n < L && guard < 8 * L + 16) begin
      check("in_ready_feed", in_ready, 1);
      case (gap)
        0:       vld = 1'b1;
        1:       vld = ((guard % 2) == 0);
        default: vld = ($urandom_range(0, 2) != 0);
      endcase
      in_valid = vld;
      in_data  = vld ? terms[n] : 21'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
      if (vld) begin
        expd = 32'(terms[n]); sum += 32'(terms[n]); n++;
      end else begin
        expd = 0;
      end
      check("digit_in", digit_in, expd);
      check("trunc_ena", trunc_ena, (n > thr) ? 0 : 1);
      clr_step(1'b0);
      guard++;
    end
    if (n < L) check("feed_timeout", n, L);
    check("in_ready_after_last", in_ready, 0);
    for (int d = 1; d < PIPE_LAT; d++) begin
      in_valid = 1'($urandom); in_data = 21'($urandom);
      @(negedge clk);
      check("digit_drain", digit_in, 0);
      check("trunc_drain", trunc_ena, 0);
      check("in_ready_drain", in_ready, 0);
      check("busy_drain", busy, 1);
      clr_step(1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("trunc_reduce", trunc_ena, 1);
    check("rvld_capture", res_valid, 0);
    clr_step(1'b1);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      check("rvld_early", res_valid, 0);
      clr_step(1'b1);
    end
    @(negedge clk);
    expv = use_ovr ? (32'(ovr) % 32'(MODULUS)) : ((sum & 32'h3FFFFF) % 32'(MODULUS));
    check("res_valid", res_valid, 1);
    check("res_data", res_data, expv);
    check("res_lt_mod", 32'(res_data < 18'(MODULUS)), 1);
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0; start = 1'($urandom); len = 8'($urandom_range(1, 255));
      @(negedge clk);
      check("rvld_hold", res_valid, 1);
      check("rdata_hold", res_data, expv);
      check("busy_hold", busy, 1);
    end
    start = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("rvld_clear", res_valid, 0);
    check("busy_idle", busy, 0);
    check("rdata_keep", res_data, expv);
    ovr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    res_ready = 1'b0; ovr_en = 1'b0; ovr_val = '0;
    e1 = 1'b1; e2 = 1'b1; e3 = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    terms = '{21'd177100, 21'd176147, 21'd147147};
    run_txn(3, 0, 0, 1'b0, 22'd0);

    fill(1, 0);
    run_txn(1, 0, 0, 1'b1, 22'd4194303);
    run_txn(1, 0, 0, 1'b1, 22'd354294);
    run_txn(1, 0, 0, 1'b1, 22'd177146);

    fill(4, 0);
    run_txn(4, 1, 0, 1'b0, 22'd0);

    fill(8, 0);
    run_txn(8, 0, 0, 1'b0, 22'd0);
    fill(2, 0);
    run_txn(2, 0, 0, 1'b0, 22'd0);

    fill(3, 0);
    run_txn(3, 2, 3, 1'b0, 22'd0);
    @(negedge clk); start = 1'b1; len = 8'd0;
    @(negedge clk); start = 1'b0;
    check("len0_busy", busy, 0);
    check("len0_in_ready", in_ready, 0);
    @(negedge clk);
    check("len0_busy2", busy, 0);

    // Abandon an accumulation mid-feed with an asynchronous reset.
    fill(6, 0);
    @(negedge clk); start = 1'b1; len = 8'd6;
    @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = terms[0];
    @(negedge clk); in_data = terms[1];
    @(negedge clk); in_valid = 1'b0;
    check("midrst_digit", digit_in, 32'(terms[1]));
    check("midrst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_rvld", res_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    terms = '{21'd177147};
    run_txn(1, 0, 0, 1'b0, 22'd0);

    for (int t = 0; t < 12; t++) begin
      int L;
      L = $urandom_range(1, 24);
      fill(L, t % 3 == 1);
      run_txn(L, 2, $urandom_range(0, 3), (t % 4) == 3, 22'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mod_accum_seq.md
MOD_ACCUM_SEQ -- requirements
Module: mod_accum_seq

Interface
REQ-001 Parameter MODULUS, default 177147, modulus of the residue channel; must satisfy 16*MODULUS < 2^22 <= 32*MODULUS.
REQ-002 Parameter LEN_W, default 8, width of the term count.
REQ-003 Parameter PIPE_LAT, default 4, cycles from the last term on digit_in until accum_ is final.
REQ-004 Parameter TRUNC_TAIL, default 5, number of final terms that run with truncation disabled.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle request to begin a dot-product accumulation.
REQ-008 len  in  LEN_W  number of terms, sampled when start is accepted.
REQ-009 in_valid / in_data / in_ready  in/in[21 bits: 21]/out  term stream with a valid/ready handshake; in_data is 21 bits.
REQ-010 digit_in  out  21  term presented to the accumulator pipe.
REQ-011 clear_1, clear_2, clear_3  out  1 each  staggered accumulator-stage clears.
REQ-012 trunc_ena  out  1  accumulator truncation enable.
REQ-013 accum_  in  22  accumulator pipe output.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 res_valid / res_data / res_ready  out/out[18]/in  reduced residue output with a valid/ready handshake.

Function
REQ-016 The FSM SHALL have the states IDLE, FEED, DRAIN, REDUCE and OUT.
REQ-017 IDLE: start=1 with len!=0 latches len and moves to FEED. start with len==0, or start in any other state, is ignored.
REQ-018 FEED: in_ready=1, decoded combinationally from the state. A transfer (in_valid & in_ready) registers in_data onto digit_in on the next edge and increments the term count. A cycle with no transfer registers 0 onto digit_in.
REQ-019 FEED exits to DRAIN on the edge that accepts term number len; in_ready is 0 from DRAIN onward.
REQ-020 DRAIN: digit_in=0. After exactly PIPE_LAT cycles, accum_ is captured into a 22-bit register r and the FSM moves to REDUCE.
REQ-021 REDUCE: exactly 5 cycles. On cycle k=0..4, with s=(16>>k)*MODULUS, r <= r-s if r>=s, else r is unchanged. Afterwards r[17:0] is loaded into res_data, res_valid is set, and the FSM moves to OUT.
REQ-022 OUT: res_valid and res_data are held stable until res_ready=1. On that edge res_valid clears and the FSM returns to IDLE. res_data keeps its last value.
REQ-023 clear_1 SHALL be registered: 0 while in FEED or DRAIN, 1 otherwise.
REQ-024 clear_2 SHALL be clear_1 delayed by one cycle, and clear_3 SHALL be clear_2 delayed by one cycle. Both come from a shift chain that is never short-circuited.
REQ-025 trunc_ena SHALL be registered and drop to 0 in the same cycle that digit_in carries term index max(len-TRUNC_TAIL,0), counting from 0. It stays 0 through DRAIN and returns to 1 on entry to REDUCE.
REQ-026 Invariant: res_data < MODULUS, and res_data = accum_ mod MODULUS for every 22-bit accum_.

Reset
REQ-027 On reset_n=0, asynchronously: state=IDLE, digit_in=0, clear_1=clear_2=clear_3=1, trunc_ena=1, res_valid=0, res_data=0, busy=0, term count=0, r=0.
REQ-028 Reset asserted mid-operation SHALL abandon the accumulation, produce no res_valid pulse, and require a new start.

Verification
REQ-029 len=3, terms 177100/176147/147147 with no gaps, bench accumulator model = adder with PIPE_LAT latency -> digit_in shows the three values on consecutive cycles; clear_1/2/3 fall on consecutive cycles; res_data=(500394 mod 177147)=146100.
REQ-030 Captured accum_=4194303 -> res_data=119922 exactly 5 cycles after capture; accum_=354294 -> 0; accum_=177146 -> 177146.
REQ-031 len=4 with in_valid low on alternate cycles -> digit_in=0 on each bubble, exactly 4 terms accepted, and in_ready=0 after the 4th.
REQ-032 len=8, TRUNC_TAIL=5 -> trunc_ena=0 first aligned with term index 3 and back to 1 on REDUCE entry; len=2 -> trunc_ena=0 from term 0.
REQ-033 res_ready held low for 3 cycles in OUT -> res_valid=1 and res_data unchanged for all 3 cycles; released -> IDLE on the next edge; start with len=0 -> busy stays 0.
REQ-034 reset_n pulsed low during FEED after 2 of 6 terms -> all outputs at their reset values immediately; a following start with len=1 and term 177147 -> res_data=0.
